// File: rtl/dram_device_model.sv
// dram_device_model: single-bank SDRAM model with open-row register, byte-masked writes and CAS-latency read pipeline
// Optional DRAM_TIMING_CHECK_EN builds tRCD/tRP counters, a sticky timing_err flag and a violation log.
module dram_device_model #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10,
  parameter int T_CL     = 5,
  parameter int T_RCD    = 5,
  parameter int T_RP     = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic [31:0] DRAM_Q,
  output logic        DRAM_valid,
  output logic        timing_err
);
  logic [31:0] mem [2**(ROW_BITS+COL_BITS)];
  logic [ROW_BITS-1:0] open_row_q, open_row_d;
  logic row_open_q, row_open_d;
  logic [T_CL-1:0] v_q, v_d;
  logic [31:0] d_q [T_CL];
  logic [31:0] d_d [T_CL];
  logic pre, act, col, rd, wr_ok, rd_ok;
  logic [ROW_BITS+COL_BITS-1:0] addr;
  always_comb begin
    pre   = !DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'h0;
    act   = !DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF;
    col   = !DRAM_CSn && DRAM_RASn && !DRAM_CASn;
    rd    = col && DRAM_WEn == 4'hF;
    wr_ok = col && DRAM_WEn != 4'hF && row_open_q;
    rd_ok = rd && row_open_q;
    addr  = {open_row_q, DRAM_A[COL_BITS-1:0]};
    open_row_d = act ? DRAM_A[ROW_BITS-1:0] : open_row_q;
    row_open_d = pre ? 1'b0 : act ? 1'b1 : row_open_q;
    v_d    = v_q << 1;
    v_d[0] = rd_ok;
    d_d[0] = rd_ok ? mem[addr] : d_q[0];
    // data only advances with a valid so the last stage holds the most recent read word
    for (int i = 1; i < T_CL; i++)
      d_d[i] = v_q[i-1] ? d_q[i-1] : d_q[i];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      open_row_q <= '0;
      row_open_q <= 1'b0;
      v_q        <= '0;
      d_q        <= '{default: '0};
    end else begin
      open_row_q <= open_row_d;
      row_open_q <= row_open_d;
      v_q        <= v_d;
      d_q        <= d_d;
    end
  always_ff @(posedge clk)
    if (wr_ok)
      for (int i = 0; i < 4; i++)
        if (!DRAM_WEn[i]) mem[addr][8*i +: 8] <= DRAM_D[8*i +: 8];
  assign DRAM_valid = v_q[T_CL-1];
  assign DRAM_Q     = d_q[T_CL-1];
`ifdef DRAM_TIMING_CHECK_EN
  localparam int CW = 8;
  logic [CW-1:0] trcd_q, trcd_d, trp_q, trp_d;
  logic [31:0] cyc_q, cyc_d;
  logic err_q, err_d, viol;
  always_comb begin
    trcd_d = act ? CW'(T_RCD) : trcd_q - CW'(trcd_q != 0);
    trp_d  = pre ? CW'(T_RP) : trp_q - CW'(trp_q != 0);
    cyc_d  = cyc_q + 32'd1;
    viol   = (col && (!row_open_q || trcd_q != 0)) || (act && (row_open_q || trp_q != 0)) || (pre && !row_open_q);
    err_d  = err_q || viol;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      trcd_q <= '0;
      trp_q  <= '0;
      cyc_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      trcd_q <= trcd_d;
      trp_q  <= trp_d;
      cyc_q  <= cyc_d;
      err_q  <= err_d;
    end
  always_ff @(posedge clk)
    if (rstn && viol)
      $display("dram_device_model: timing violation at cycle %0d on %s", cyc_q,
               pre ? "PRE" : act ? "ACT" : rd ? "READ" : "WRITE");
  assign timing_err = err_q;
`else
  assign timing_err = 1'b0;
`endif
endmodule
